// File: rtl/fp_normalize_seq.sv
`timescale 1ns/1ps
// fp_normalize_seq: handshaked sequential normalizer / round-to-nearest-even
// for the FP datapath. The input is {carry, hidden, fraction, guard, sticky} with
// a biased exponent that has one headroom bit. The output is a packed
// exponent/fraction pair with overflow, denormal, zero and inexact flags.
// Optional build macro FP_NORM_LZC_EN: when it is defined, the left shift is
// done in a single NORM cycle using a leading-zero count. Otherwise one bit is
// shifted per cycle. Both builds give bit-identical results.
module fp_normalize_seq #(
  parameter int MB = 10,
  parameter int EB = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          IN_SIGN,
  input  logic [MB+3:0] IN_MANT,
  input  logic [EB:0]   IN_EXP,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_SIGN,
  output logic [EB-1:0] OUT_EXP,
  output logic [MB-1:0] OUT_FRAC,
  output logic          OUT_OVF,
  output logic          OUT_UNF,
  output logic          OUT_ZERO,
  output logic          OUT_INEXACT
);

  localparam int MW = MB + 4;  // working mantissa width
  localparam int XW = EB + 2;  // working exponent width, wide enough to never wrap
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EB) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state_reg, state_next;
  logic            sign_reg;
  logic [MW-1:0]   m_reg, m_next;
  logic [XW-1:0]   e_reg, e_next;

  logic            guard, sticky, round_up, hidden, ovf;
  logic [MB+1:0]   sig_sum;
  logic [XW-1:0]   e_rnd;
  logic [EB-1:0]   exp_field;
  logic [MB-1:0]   frac_field;

  assign IN_READY  = (state_reg == IDLE);
  assign OUT_VALID = (state_reg == DONE);

`ifdef FP_NORM_LZC_EN
  logic [XW-1:0] lzc, shift_amt;

  // Leading-zero count below the carry bit, clamped so the exponent never drops below 1
  always_comb begin
    lzc = XW'(MW - 1);
    for (int i = 0; i < MW - 1; i++) begin
      if (m_reg[i]) lzc = XW'(MW - 2 - i);
    end
    shift_amt = (lzc < e_reg - XW'(1)) ? lzc : e_reg - XW'(1);
  end
`endif

  // Round-to-nearest-even on the normalised mantissa and build the packed fields
  always_comb begin
    guard      = m_reg[1];
    sticky     = m_reg[0];
    round_up   = guard & (sticky | m_reg[2]);
    sig_sum    = {1'b0, m_reg[MB+2:2]} + {{(MB+1){1'b0}}, round_up};
    e_rnd      = e_reg;
    hidden     = sig_sum[MB];
    frac_field = sig_sum[MB-1:0];
    if (sig_sum[MB+1]) begin
      // Mantissa rolled over 2.0: renormalise to 1.0 and bump the exponent
      hidden     = 1'b1;
      frac_field = '0;
      e_rnd      = e_reg + XW'(1);
    end
    // A denormal that rounds into the hidden bit has e=1, which becomes field 1 here
    exp_field = hidden ? e_rnd[EB-1:0] : '0;
    ovf       = (e_rnd >= EXP_MAX);
  end

  // Next-state and working-register update for the control FSM
  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    e_next     = e_reg;
    case (state_reg)
      IDLE: begin
        if (IN_VALID) begin
          m_next     = IN_MANT;
          // A zero exponent field carries the same scale as exponent 1
          e_next     = (IN_EXP == '0) ? XW'(1) : {1'b0, IN_EXP};
          state_next = NORM;
        end
      end
      NORM: begin
        if (m_reg[MW-1]) begin
          // Carry set: shift right once, folding the bits shifted out into sticky
          m_next     = {1'b0, m_reg[MW-1:2], m_reg[1] | m_reg[0]};
          e_next     = e_reg + XW'(1);
          state_next = ROUND;
        end else if (m_reg == '0) begin
          e_next     = '0;
          state_next = ROUND;
        end
`ifdef FP_NORM_LZC_EN
        else begin
          m_next     = m_reg << shift_amt;
          e_next     = e_reg - shift_amt;
          state_next = ROUND;
        end
`else
        else if (m_reg[MW-2]) begin
          state_next = ROUND;
        end else if (e_reg <= XW'(1)) begin
          state_next = ROUND;
        end else begin
          m_next = {m_reg[MW-2:0], 1'b0};
          e_next = e_reg - XW'(1);
        end
`endif
      end
      ROUND:   state_next = DONE;
      DONE:    if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset discards any transaction in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Working mantissa/exponent/sign registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_reg    <= '0;
      e_reg    <= '0;
      sign_reg <= 1'b0;
    end else begin
      m_reg <= m_next;
      e_reg <= e_next;
      if (state_reg == IDLE && IN_VALID) sign_reg <= IN_SIGN;
    end
  end

  // Output registers are loaded in ROUND and held through DONE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_SIGN    <= 1'b0;
      OUT_EXP     <= '0;
      OUT_FRAC    <= '0;
      OUT_OVF     <= 1'b0;
      OUT_UNF     <= 1'b0;
      OUT_ZERO    <= 1'b0;
      OUT_INEXACT <= 1'b0;
    end else if (state_reg == ROUND) begin
      OUT_SIGN    <= sign_reg;
      OUT_EXP     <= ovf ? '1 : exp_field;
      OUT_FRAC    <= ovf ? '0 : frac_field;
      OUT_OVF     <= ovf;
      OUT_UNF     <= !ovf && (exp_field == '0) && (frac_field != '0);
      OUT_ZERO    <= !ovf && (exp_field == '0) && (frac_field == '0);
      OUT_INEXACT <= guard | sticky;
    end
  end

endmodule

// File: tb/tb_fp_normalize_seq.sv
`timescale 1ns/1ps
// Testbench for fp_normalize_seq: directed vector table, randomized transactions
// against a value-level reference model, backpressure and mid-operation reset.
module tb_fp_normalize_seq;
  localparam int MB = 10;
  localparam int EB = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_SIGN = 1'b0;
  logic [MB+3:0] IN_MANT = '0;
  logic [EB:0]   IN_EXP = '0;
  logic          OUT_READY = 1'b0;
  logic          IN_READY, OUT_VALID, OUT_SIGN, OUT_OVF, OUT_UNF, OUT_ZERO, OUT_INEXACT;
  logic [EB-1:0] OUT_EXP;
  logic [MB-1:0] OUT_FRAC;

  fp_normalize_seq #(.MB(MB), .EB(EB)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SIGN(IN_SIGN),
    .IN_MANT(IN_MANT), .IN_EXP(IN_EXP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SIGN(OUT_SIGN),
    .OUT_EXP(OUT_EXP), .OUT_FRAC(OUT_FRAC), .OUT_OVF(OUT_OVF),
    .OUT_UNF(OUT_UNF), .OUT_ZERO(OUT_ZERO), .OUT_INEXACT(OUT_INEXACT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int exp_f; int frac; int ovf; int unf; int zero; int inexact; int shifts;
  } res_t;

  typedef struct {
    logic s; logic [MB+3:0] mant; logic [EB:0] ex;
    int e_exp; int e_frac; int e_ovf; int e_unf; int e_zero; int e_inex; int e_lat;
  } vec_t;

  // Captured result of the last transaction
  int c_sign, c_exp, c_frac, c_ovf, c_unf, c_zero, c_inex, c_lat;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Value-level model: normalise with a single clamped shift, then round half-to-even
  function automatic res_t ref_model(input int mant, input int ex);
    res_t r;
    int m, e, g, s, sig, up, hidden, p, sh;
    m = mant;
    e = (ex == 0) ? 1 : ex;
    r.shifts = 0;
    if (m >= (1 << (MB + 3))) begin
      m = ((m >> 1) & ~1) | (((m & 3) != 0) ? 1 : 0);
      e = e + 1;
    end else if (m == 0) begin
      e = 0;
    end else begin
      p = 0;
      for (int i = 0; i <= MB + 2; i++) if (((m >> i) & 1) != 0) p = i;
      sh = (MB + 2) - p;
      if (sh > e - 1) sh = e - 1;
      m = m << sh;
      e = e - sh;
      r.shifts = sh;
    end
    g = (m >> 1) & 1;
    s = m & 1;
    sig = m >> 2;
    up = g & (s | (sig & 1));
    sig = sig + up;
    if (sig >= (1 << (MB + 1))) begin
      sig = 1 << MB;
      e = e + 1;
    end
    hidden = (sig >> MB) & 1;
    r.frac = sig & ((1 << MB) - 1);
    r.exp_f = (hidden != 0) ? e : 0;
    r.ovf = 0;
    if (e >= (1 << EB) - 1) begin
      r.exp_f = (1 << EB) - 1;
      r.frac = 0;
      r.ovf = 1;
    end
    r.unf = (r.exp_f == 0 && r.frac != 0) ? 1 : 0;
    r.zero = (r.exp_f == 0 && r.frac == 0) ? 1 : 0;
    r.inexact = g | s;
    return r;
  endfunction

  function automatic int lat_of(input int iter_lat);
`ifdef FP_NORM_LZC_EN
    return 3;
`else
    return iter_lat;
`endif
  endfunction

  // One full transaction: accept, count edges to OUT_VALID, capture, hand off
  task automatic do_txn(input logic s, input logic [MB+3:0] mant, input logic [EB:0] ex);
    int n;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    IN_SIGN = s; IN_MANT = mant; IN_EXP = ex; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    c_lat = 1;
    while (!OUT_VALID && c_lat < 40) begin
      @(posedge CLK); #1; c_lat++;
    end
    c_sign = OUT_SIGN; c_exp = OUT_EXP; c_frac = OUT_FRAC; c_ovf = OUT_OVF;
    c_unf = OUT_UNF; c_zero = OUT_ZERO; c_inex = OUT_INEXACT;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " lat"}, c_lat, lat_of(v.e_lat));
    check({tag, " sign"}, c_sign, int'(v.s));
    check({tag, " exp"}, c_exp, v.e_exp);
    check({tag, " frac"}, c_frac, v.e_frac);
    check({tag, " ovf"}, c_ovf, v.e_ovf);
    check({tag, " unf"}, c_unf, v.e_unf);
    check({tag, " zero"}, c_zero, v.e_zero);
    check({tag, " inexact"}, c_inex, v.e_inex);
  endtask

  vec_t vt[13];

  initial begin
    res_t r;
    vec_t v;
    int seen;
    logic [MB+3:0] rm;
    logic [EB:0] re;
    logic rs;

    //         s     mant        ex    exp frac    ovf unf zero inex lat
    vt[0]  = '{1'b0, 14'h2000, 6'd15, 16, 0,        0, 0, 0, 0, 3};
    vt[1]  = '{1'b1, 14'h0200, 6'd20, 17, 0,        0, 0, 0, 0, 6};
    vt[2]  = '{1'b0, 14'h0200, 6'd2,  0,  10'h100,  0, 1, 0, 0, 4};
    vt[3]  = '{1'b0, 14'h1006, 6'd10, 10, 2,        0, 0, 0, 1, 3};
    vt[4]  = '{1'b1, 14'h1002, 6'd10, 10, 0,        0, 0, 0, 1, 3};
    vt[5]  = '{1'b0, 14'h1FFF, 6'd14, 15, 0,        0, 0, 0, 1, 3};
    vt[6]  = '{1'b1, 14'h2000, 6'd30, 31, 0,        1, 0, 0, 0, 3};
    vt[7]  = '{1'b0, 14'h0000, 6'd12, 0,  0,        0, 0, 1, 0, 3};
    vt[8]  = '{1'b0, 14'h0800, 6'd0,  0,  10'h200,  0, 1, 0, 0, 3};
    vt[9]  = '{1'b1, 14'h0FFF, 6'd1,  1,  0,        0, 0, 0, 1, 3};
    vt[10] = '{1'b0, 14'h0001, 6'd40, 28, 0,        0, 0, 0, 0, 15};
    vt[11] = '{1'b0, 14'h0002, 6'd40, 29, 0,        0, 0, 0, 0, 14};
    vt[12] = '{1'b1, 14'h3FFF, 6'd20, 22, 0,        0, 0, 0, 1, 3};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset in_ready", IN_READY, 1);
    check("reset out_valid", OUT_VALID, 0);
    check("reset out_exp", OUT_EXP, 0);
    check("reset out_frac", OUT_FRAC, 0);
    check("reset flags", {OUT_SIGN, OUT_OVF, OUT_UNF, OUT_ZERO, OUT_INEXACT}, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_txn(vt[i].s, vt[i].mant, vt[i].ex);
      $display("vec %0d mant=%h exp=%0d -> exp=%0d frac=%h ovf=%0d unf=%0d zero=%0d inex=%0d lat=%0d",
               i, vt[i].mant, vt[i].ex, c_exp, c_frac, c_ovf, c_unf, c_zero, c_inex, c_lat);
      check_vec($sformatf("vec%0d", i), vt[i]);
      check($sformatf("vec%0d idle after", i), {OUT_VALID, IN_READY}, 1);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 150; i++) begin
      rs = 1'(($urandom) & 1);
      rm = 14'($urandom & ((1 << $urandom_range(0, 14)) - 1));
      re = 6'($urandom_range(0, 63));
      r = ref_model(int'(rm), int'(re));
      v = '{rs, rm, re, r.exp_f, r.frac, r.ovf, r.unf, r.zero, r.inexact, 3 + r.shifts};
      do_txn(rs, rm, re);
      $display("rnd %0d mant=%h exp=%0d -> exp=%0d frac=%h ovf=%0d unf=%0d zero=%0d inex=%0d lat=%0d",
               i, rm, re, c_exp, c_frac, c_ovf, c_unf, c_zero, c_inex, c_lat);
      check_vec($sformatf("rnd%0d", i), v);
    end

    // Backpressure: result held, second request ignored
    IN_SIGN = 1'b1; IN_MANT = 14'h1006; IN_EXP = 6'd10; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    seen = 1;
    while (!OUT_VALID && seen < 40) begin
      @(posedge CLK); #1; seen++;
    end
    check("bp latency", seen, 3);
    IN_SIGN = 1'b0; IN_MANT = 14'h2000; IN_EXP = 6'd5; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      $display("bp cycle %0d valid=%0d in_ready=%0d exp=%0d frac=%h", i, OUT_VALID, IN_READY, OUT_EXP, OUT_FRAC);
      check("bp valid held", OUT_VALID, 1);
      check("bp in_ready", IN_READY, 0);
      check("bp exp held", OUT_EXP, 10);
      check("bp frac held", OUT_FRAC, 2);
      check("bp sign held", OUT_SIGN, 1);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check("bp release valid", OUT_VALID, 0);
    check("bp release in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    check("bp no second accept", IN_READY, 1);

    // Reset during a three-shift normalisation
    IN_SIGN = 1'b0; IN_MANT = 14'h0200; IN_EXP = 6'd20; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    $display("mid-reset out_exp=%0d out_frac=%h in_ready=%0d", OUT_EXP, OUT_FRAC, IN_READY);
    check("rst out_exp", OUT_EXP, 0);
    check("rst out_frac", OUT_FRAC, 0);
    check("rst flags", {OUT_SIGN, OUT_OVF, OUT_UNF, OUT_ZERO, OUT_INEXACT}, 0);
    check("rst out_valid", OUT_VALID, 0);
    check("rst in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    check("rst no out_valid", seen, 0);
    do_txn(vt[1].s, vt[1].mant, vt[1].ex);
    $display("post-reset txn exp=%0d frac=%h lat=%0d", c_exp, c_frac, c_lat);
    check_vec("post-reset", vt[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
